// File: rtl/array3d_pkg.sv
// Shared types and helpers for the 3-D array writer: opcodes, FSM states,
// default dimensions, linear addressing and modulo-N cursor stepping.
package array3d_pkg;

  localparam int unsigned D0 = 2;
  localparam int unsigned D1 = 3;
  localparam int unsigned D2 = 4;
  localparam int unsigned N  = D0 * D1 * D2;

  typedef enum logic [2:0] {
    OP_NOP        = 3'd0,
    OP_SETPOS     = 3'd1,
    OP_WR_PREINC  = 3'd2,
    OP_WR_POSTINC = 3'd3,
    OP_WR_PREDEC  = 3'd4,
    OP_WR_POSTDEC = 3'd5,
    OP_FILL       = 3'd6,
    OP_CLEAR      = 3'd7
  } array3d_op_e;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SWEEP = 1'b1
  } array3d_state_e;

  // Row-major linear address of element [i][j][k].
  function automatic int unsigned lin_addr(input int unsigned i,
                                           input int unsigned j,
                                           input int unsigned k,
                                           input int unsigned d1 = D1,
                                           input int unsigned d2 = D2);
    return i * d1 * d2 + j * d2 + k;
  endfunction

  // One cursor step up (up=1) or down (up=0), wrapping modulo n. The 32-bit
  // working width leaves headroom above the cursor width, so p+1 never
  // overflows before the wrap compare; n need not be a power of two.
  function automatic int unsigned pos_step(input int unsigned p,
                                           input logic        up,
                                           input int unsigned n = N);
    if (up) return (p + 32'd1 == n) ? 32'd0 : p + 32'd1;
    else    return (p == 32'd0) ? n - 32'd1 : p - 32'd1;
  endfunction

endpackage

// File: rtl/array3d_autoinc_writer_if.sv
// Command, status and read-port bundle of the 3-D array writer.
// Handshake: a command transfers on a rising edge where cmd_valid && cmd_ready;
// the master holds cmd_op/cmd_pos/cmd_data stable while cmd_valid is high, and
// cmd_ready does not depend on cmd_valid.
interface array3d_autoinc_writer_if #(
  parameter int W  = 32,
  parameter int PW = 5,
  parameter int IW = 1,
  parameter int JW = 2,
  parameter int KW = 2
);
  import array3d_pkg::*;

  logic           cmd_valid;
  logic           cmd_ready;
  logic [2:0]     cmd_op;
  logic [PW-1:0]  cmd_pos;
  logic [W-1:0]   cmd_data;
  logic [PW-1:0]  pos;
  logic           busy;
  logic           wr_done;
  logic           cmd_err;
  logic [IW-1:0]  rd_i;
  logic [JW-1:0]  rd_j;
  logic [KW-1:0]  rd_k;
  logic [W-1:0]   rd_data;
  logic           rd_err;
  array3d_state_e dbg_state;

  modport master (
    output cmd_valid, cmd_op, cmd_pos, cmd_data, rd_i, rd_j, rd_k,
    input  cmd_ready, pos, busy, wr_done, cmd_err, rd_data, rd_err, dbg_state
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_pos, cmd_data, rd_i, rd_j, rd_k,
    output cmd_ready, pos, busy, wr_done, cmd_err, rd_data, rd_err, dbg_state
  );

endinterface

// File: rtl/array3d_rd_port.sv
// Registered read port: range-checks the three indices, linearises them and
// registers the addressed element one cycle later.
module array3d_rd_port #(
  parameter int unsigned D0 = 2,
  parameter int unsigned D1 = 3,
  parameter int unsigned D2 = 4,
  parameter int unsigned W  = 32,
  parameter int          IW = 1,
  parameter int          JW = 2,
  parameter int          KW = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [IW-1:0] rd_i,
  input  logic [JW-1:0] rd_j,
  input  logic [KW-1:0] rd_k,
  input  logic [W-1:0]  mem [D0*D1*D2],
  output logic [W-1:0]  rd_data,
  output logic          rd_err
);
  import array3d_pkg::*;

  localparam int unsigned NN = D0 * D1 * D2;
  localparam int AW = (NN > 1) ? $clog2(NN) : 1;

  logic          oob;
  logic [AW-1:0] lin;

  assign oob = (32'(rd_i) >= D0) || (32'(rd_j) >= D1) || (32'(rd_k) >= D2);
  assign lin = AW'(lin_addr(32'(rd_i), 32'(rd_j), 32'(rd_k), D1, D2));

  // Sample the addressed element; out-of-range indices read as zero with rd_err.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data <= '0;
      rd_err  <= 1'b0;
    end else if (oob) begin
      rd_data <= '0;
      rd_err  <= 1'b1;
    end else begin
      rd_data <= mem[lin];
      rd_err  <= 1'b0;
    end
  end

endmodule

// File: rtl/array3d_autoinc_writer.sv
// Array storage, linear cursor and fill/clear sweep FSM for the 2x3x4 array.
// Single-entry writes use C-style pre/post increment/decrement addressing;
// FILL/CLEAR sweep all N entries, one per cycle, while cmd_ready is low.
module array3d_autoinc_writer #(
  parameter int unsigned D0 = array3d_pkg::D0,
  parameter int unsigned D1 = array3d_pkg::D1,
  parameter int unsigned D2 = array3d_pkg::D2,
  parameter int unsigned W  = 32
) (
  input logic                    clk,
  input logic                    rst_n,
  array3d_autoinc_writer_if.slave bus
);
  import array3d_pkg::*;

  localparam int unsigned NN = D0 * D1 * D2;
  localparam int PW = (NN > 1) ? $clog2(NN) : 1;
  localparam int IW = (D0 > 1) ? $clog2(D0) : 1;
  localparam int JW = (D1 > 1) ? $clog2(D1) : 1;
  localparam int KW = (D2 > 1) ? $clog2(D2) : 1;
  localparam logic [PW-1:0] LAST = PW'(NN - 1);

  array3d_state_e state_q, state_d;
  array3d_op_e    op;
  logic [PW-1:0]  pos_q, pos_d;
  logic [PW-1:0]  sc_q;
  logic [W-1:0]   base_q;
  logic           clear_q;
  logic           done_q, done_d;
  logic           err_q, err_d;
  logic           accept;
  logic           wr_en;
  logic [PW-1:0]  wr_addr;
  logic [W-1:0]   wr_val;
  logic [W-1:0]   mem [NN];

  assign op     = array3d_op_e'(bus.cmd_op);
  assign accept = bus.cmd_valid && (state_q == ST_IDLE);

  // Next state, cursor, write port and completion pulses.
  always_comb begin
    state_d = state_q;
    pos_d   = pos_q;
    wr_en   = 1'b0;
    wr_addr = pos_q;
    wr_val  = bus.cmd_data;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          done_d = 1'b1;
          case (op)
            OP_SETPOS: begin
              if (bus.cmd_pos <= LAST) pos_d = bus.cmd_pos;
              else                     err_d = 1'b1;
            end
            OP_WR_PREINC: begin
              pos_d   = PW'(pos_step(32'(pos_q), 1'b1, NN));
              wr_en   = 1'b1;
              wr_addr = pos_d;
            end
            OP_WR_POSTINC: begin
              pos_d = PW'(pos_step(32'(pos_q), 1'b1, NN));
              wr_en = 1'b1;
            end
            OP_WR_PREDEC: begin
              pos_d   = PW'(pos_step(32'(pos_q), 1'b0, NN));
              wr_en   = 1'b1;
              wr_addr = pos_d;
            end
            OP_WR_POSTDEC: begin
              pos_d = PW'(pos_step(32'(pos_q), 1'b0, NN));
              wr_en = 1'b1;
            end
            OP_FILL, OP_CLEAR: begin
              state_d = ST_SWEEP;
              done_d  = 1'b0;
            end
            default: ;
          endcase
        end
      end
      ST_SWEEP: begin
        wr_en   = 1'b1;
        wr_addr = sc_q;
        wr_val  = clear_q ? '0 : base_q + W'(sc_q);
        if (sc_q == LAST) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Control registers: FSM state, cursor, sweep counter and latched sweep command.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      pos_q   <= '0;
      sc_q    <= '0;
      base_q  <= '0;
      clear_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pos_q   <= pos_d;
      done_q  <= done_d;
      err_q   <= err_d;
      if (accept && (op == OP_FILL || op == OP_CLEAR)) begin
        base_q  <= bus.cmd_data;
        clear_q <= (op == OP_CLEAR);
        sc_q    <= '0;
      end else if (state_q == ST_SWEEP) begin
        sc_q <= (sc_q == LAST) ? '0 : sc_q + 1'b1;
      end
    end
  end

  // Array storage; reset clears every entry asynchronously, aborting any sweep.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int n = 0; n < int'(NN); n++) mem[n] <= '0;
    end else if (wr_en) begin
      mem[wr_addr] <= wr_val;
    end
  end

  array3d_rd_port #(
    .D0(D0), .D1(D1), .D2(D2), .W(W), .IW(IW), .JW(JW), .KW(KW)
  ) u_rd_port (
    .clk    (clk),
    .rst_n  (rst_n),
    .rd_i   (bus.rd_i),
    .rd_j   (bus.rd_j),
    .rd_k   (bus.rd_k),
    .mem    (mem),
    .rd_data(bus.rd_data),
    .rd_err (bus.rd_err)
  );

  assign bus.cmd_ready = (state_q == ST_IDLE);
  assign bus.busy      = (state_q == ST_SWEEP);
  assign bus.pos       = pos_q;
  assign bus.wr_done   = done_q;
  assign bus.cmd_err   = err_q;
  assign bus.dbg_state = state_q;

endmodule
